// File: rtl/vc32_mem_responder_if.sv
// Byte-bus signal bundle between the vc32 CPU wrapper (master) and the memory
// responder (slave).
interface vc32_mem_responder_if;
  logic [7:0] bus_in;
  logic       latch_hi;
  logic       latch_lo;
  logic       write;
  logic       ind;
  logic [7:0] rdata_out;
  logic       irq;
  logic       proto_err;
  logic       wp_err;

  modport master (
    output bus_in, latch_hi, latch_lo, write, ind,
    input  rdata_out, irq, proto_err, wp_err
  );

  modport slave (
    input  bus_in, latch_hi, latch_lo, write, ind,
    output rdata_out, irq, proto_err, wp_err
  );
endinterface

// File: rtl/vc32_mem_responder.sv
// vc32 byte-bus memory responder: strobe decoder, byte RAM, IRQ mailbox.
// Optional write protection of the low ROM_BYTES bytes via VC32_RESP_WPROT_EN.
module vc32_mem_responder #(
  parameter int PA        = 22,
  parameter int AW        = 12,
  parameter int ROM_BYTES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  vc32_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GOT_HI, GOT_MID, ADDR_OK} state_e;

  localparam logic [PA-1:0] MBOX = {PA{1'b1}};

  if (ROM_BYTES > (1 << PA)) begin : g_rom_chk
    $error("ROM_BYTES exceeds the physical address space");
  end

  // Assert asynchronously, release on a clock edge so no flop sees a runt release.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  state_e           state_q, state_d;
  logic [PA-1:1]    addr_q, addr_d;
  logic             irq_q, irq_d;
  logic             perr_q, perr_d;
  logic             mem_we;
  logic             rd_en;
  logic [PA-1:0]    rd_addr;
  logic [PA-1:0]    eff_addr;
  logic [PA-1:0]    mid_addr;
  logic [7:0]       mem [2**AW];

  logic hi, lo, wr;
  assign hi = bus.latch_hi;
  assign lo = bus.latch_lo;
  assign wr = bus.write;

  assign eff_addr = {addr_q, bus.ind};
  // During the low-address cycle the RAM is read with the byte still on the bus.
  assign mid_addr = {addr_q[PA-1:8], bus.bus_in[7:1], bus.ind};

`ifdef VC32_RESP_WPROT_EN
  localparam logic [PA:0] ROM_LIM = (PA+1)'(ROM_BYTES);
  logic wp_hit;
  logic wp_err_q, wp_err_d;
  assign wp_hit = ({1'b0, eff_addr} < ROM_LIM);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    irq_d   = irq_q;
    perr_d  = perr_q;
    mem_we  = 1'b0;
    rd_en   = 1'b0;
    rd_addr = eff_addr;
`ifdef VC32_RESP_WPROT_EN
    wp_err_d = wp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (hi && !lo) begin
          addr_d[PA-1:16] = bus.bus_in[PA-17:0];
          state_d         = GOT_HI;
        end
        if (lo || wr) perr_d = 1'b1;
      end
      GOT_HI: begin
        if (hi && lo && !wr) begin
          addr_d[15:8] = bus.bus_in;
          state_d      = GOT_MID;
        end else begin
          perr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      GOT_MID: begin
        if (!hi && lo) begin
          rd_en   = 1'b1;
          rd_addr = mid_addr;
        end
        if (!hi && lo && !wr) begin
          addr_d[7:1] = bus.bus_in[7:1];
          state_d     = ADDR_OK;
        end else begin
          perr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ADDR_OK: begin
        rd_en = !wr && !lo;
        // Strobes outrank write: a write alongside hi/lo is a protocol error.
        if (lo) begin
          perr_d  = 1'b1;
          state_d = IDLE;
        end else if (hi) begin
          addr_d[PA-1:16] = bus.bus_in[PA-17:0];
          state_d         = GOT_HI;
          if (wr) perr_d = 1'b1;
        end else if (wr) begin
          if (eff_addr == MBOX) irq_d = bus.bus_in[0];
`ifdef VC32_RESP_WPROT_EN
          else if (wp_hit) wp_err_d = 1'b1;
`endif
          else mem_we = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      irq_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      irq_q   <= irq_d;
      perr_q  <= perr_d;
    end
  end

`ifdef VC32_RESP_WPROT_EN
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) wp_err_q <= 1'b0;
    else            wp_err_q <= wp_err_d;
  end
  assign bus.wp_err = wp_err_q;
`else
  assign bus.wp_err = 1'b0;
`endif

  // RAM contents survive reset; the index aliases above 2^AW bytes.
  always_ff @(posedge clk) begin
    if (mem_we) mem[eff_addr[AW-1:0]] <= bus.bus_in;
  end

  assign bus.rdata_out = !rd_en            ? 8'h00 :
                         (rd_addr == MBOX) ? {7'b0, irq_q} :
                                             mem[rd_addr[AW-1:0]];
  assign bus.irq       = irq_q;
  assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_vc32_mem_responder.sv
// Directed bench for vc32_mem_responder: per-cycle vector table plus
// hand-written protocol-error, reset and write-protect sequences.
module tb_vc32_mem_responder;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  vc32_mem_responder_if bus ();

  vc32_mem_responder #(.PA(22), .AW(12), .ROM_BYTES(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hi, lo, wr, ind;
    logic [7:0] din;
    logic       ck;
    logic [7:0] rd;
    logic       irq;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic h, l, w, i, input logic [7:0] d,
                            input logic ck, input logic [7:0] rd, input logic irq);
    vec_t e;
    e.hi = h; e.lo = l; e.wr = w; e.ind = i; e.din = d;
    e.ck = ck; e.rd = rd; e.irq = irq;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge; outputs are sampled 2 ns later, well before the rising edge.
  task automatic step(input logic h, l, w, i, input logic [7:0] d);
    @(negedge clk);
    bus.latch_hi = h; bus.latch_lo = l; bus.write = w; bus.ind = i; bus.bus_in = d;
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic wr_byte(input logic [21:0] a, input logic i, input logic [7:0] d);
    step(1, 0, 0, 0, {2'b00, a[21:16]});
    step(1, 1, 0, 0, a[15:8]);
    step(0, 1, 0, i, a[7:0]);
    step(0, 0, 1, i, d);
  endtask

  // Leaves the DUT in the low-address cycle; rdata_out then holds the addressed byte.
  task automatic rd_byte(input logic [21:0] a, input logic i, output logic [7:0] d);
    step(1, 0, 0, 0, {2'b00, a[21:16]});
    step(1, 1, 0, 0, a[15:8]);
    step(0, 1, 0, i, a[7:0]);
    d = bus.rdata_out;
  endtask

  logic [7:0] rb;

  initial begin
    bus.latch_hi = 0; bus.latch_lo = 0; bus.write = 0; bus.ind = 0; bus.bus_in = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    idle(2);
    chk("reset rdata", bus.rdata_out, 8'h00);
    chk("reset irq", {7'b0, bus.irq}, 8'h00);
    chk("reset proto_err", {7'b0, bus.proto_err}, 8'h00);
    chk("reset wp_err", {7'b0, bus.wp_err}, 8'h00);
    rst_n = 1'b1;
    idle(3);

    // 16-bit write 0xBEEF to 0x012344
    v(1,0,0,0,8'h01, 1,8'h00,0);
    v(1,1,0,0,8'h23, 1,8'h00,0);
    v(0,1,0,0,8'h44, 0,8'h00,0);
    v(0,0,1,0,8'hEF, 1,8'h00,0);
    v(0,0,1,1,8'hBE, 1,8'h00,0);
    // 16-bit read back (hi cycle in ADDR_OK still reads the previous address)
    v(1,0,0,0,8'h01, 1,8'hEF,0);
    v(1,1,0,0,8'h23, 1,8'h00,0);
    v(0,1,0,0,8'h44, 1,8'hEF,0);
    v(0,0,0,1,8'h00, 1,8'hBE,0);
    // preload 0x000100 = 0x11
    v(1,0,0,0,8'h00, 1,8'hEF,0);
    v(1,1,0,0,8'h01, 1,8'h00,0);
    v(0,1,0,0,8'h00, 0,8'h00,0);
    v(0,0,1,0,8'h11, 1,8'h00,0);
    // byte write 0x5A with ind=1 to 0x000101
    v(1,0,0,0,8'h00, 1,8'h11,0);
    v(1,1,0,0,8'h01, 1,8'h00,0);
    v(0,1,0,1,8'h00, 0,8'h00,0);
    v(0,0,1,1,8'h5A, 1,8'h00,0);
    // read 0x000100
    v(1,0,0,0,8'h00, 1,8'h11,0);
    v(1,1,0,0,8'h01, 1,8'h00,0);
    v(0,1,0,0,8'h00, 1,8'h11,0);
    v(0,0,0,1,8'h00, 1,8'h5A,0);
    // aliased read of 0x001100
    v(1,0,0,0,8'h00, 1,8'h11,0);
    v(1,1,0,0,8'h11, 1,8'h00,0);
    v(0,1,0,0,8'h00, 1,8'h11,0);
    v(0,0,0,1,8'h00, 1,8'h5A,0);
    // preload 0x000FFF = 0x77 (RAM byte aliased by the mailbox)
    v(1,0,0,0,8'h00, 1,8'h11,0);
    v(1,1,0,0,8'h0F, 1,8'h00,0);
    v(0,1,0,1,8'hFE, 0,8'h00,0);
    v(0,0,1,1,8'h77, 1,8'h00,0);
    // mailbox write 0x01 -> irq rises one edge later
    v(1,0,0,1,8'h3F, 1,8'h77,0);
    v(1,1,0,0,8'hFF, 1,8'h00,0);
    v(0,1,0,1,8'hFF, 1,8'h00,0);
    v(0,0,1,1,8'h01, 1,8'h00,0);
    v(0,0,0,1,8'h00, 1,8'h01,1);
    // mailbox write 0x00
    v(1,0,0,1,8'h3F, 1,8'h01,1);
    v(1,1,0,0,8'hFF, 1,8'h00,1);
    v(0,1,0,1,8'hFF, 1,8'h01,1);
    v(0,0,1,1,8'h00, 1,8'h00,1);
    v(0,0,0,1,8'h00, 1,8'h00,0);
    // RAM 0xFFF untouched by the mailbox writes
    v(1,0,0,1,8'h00, 1,8'h00,0);
    v(1,1,0,0,8'h0F, 1,8'h00,0);
    v(0,1,0,1,8'hFE, 1,8'h77,0);
    v(0,0,0,1,8'h00, 1,8'h77,0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].hi, tbl[i].lo, tbl[i].wr, tbl[i].ind, tbl[i].din);
      if (tbl[i].ck) chk($sformatf("vec%0d rdata", i), bus.rdata_out, tbl[i].rd);
      chk($sformatf("vec%0d irq", i), {7'b0, bus.irq}, {7'b0, tbl[i].irq});
      chk($sformatf("vec%0d proto_err", i), {7'b0, bus.proto_err}, 8'h00);
    end

    // lo strobe in IDLE: sticky proto_err, later traffic still works
    do_reset();
    step(0, 1, 0, 0, 8'h00);
    idle(1);
    chk("idle lo proto_err", {7'b0, bus.proto_err}, 8'h01);
    wr_byte(22'h000020, 1'b0, 8'h3C);
    rd_byte(22'h000020, 1'b0, rb);
`ifndef VC32_RESP_WPROT_EN
    chk("post-err read 0x20", rb, 8'h3C);
`endif
    idle(2);
    chk("proto_err sticky", {7'b0, bus.proto_err}, 8'h01);

    // async reset in GOT_MID with a write pulse during reset
    wr_byte(22'h3FFFFF, 1'b1, 8'h01);
    idle(1);
    chk("irq set by mailbox", {7'b0, bus.irq}, 8'h01);
    wr_byte(22'h000130, 1'b0, 8'h66);
    rd_byte(22'h000130, 1'b0, rb);
    chk("GOT_MID live read", rb, 8'h66);
    rst_n = 1'b0;
    #1;
    chk("async reset rdata", bus.rdata_out, 8'h00);
    chk("async reset irq", {7'b0, bus.irq}, 8'h00);
    step(0, 0, 1, 0, 8'h99);
    step(0, 0, 0, 0, 8'h00);
    rst_n = 1'b1;
    idle(3);
    chk("reset clears proto_err", {7'b0, bus.proto_err}, 8'h00);
    rd_byte(22'h000130, 1'b0, rb);
    chk("target intact after reset", rb, 8'h66);

    // write together with lo in ADDR_OK: no write, proto_err
    idle(1);
    step(0, 1, 1, 0, 8'h99);
    idle(1);
    chk("write+lo proto_err", {7'b0, bus.proto_err}, 8'h01);
    rd_byte(22'h000130, 1'b0, rb);
    chk("write+lo dropped", rb, 8'h66);

    // write-protect region
    idle(1);
    wr_byte(22'h000010, 1'b0, 8'hAA);
    idle(1);
    rd_byte(22'h000010, 1'b0, rb);
`ifdef VC32_RESP_WPROT_EN
    n_cmp++;
    if (rb === 8'hAA) begin
      n_err++;
      $display("FAIL wprot data: got %02h expected not aa", rb);
    end
    chk("wprot wp_err", {7'b0, bus.wp_err}, 8'h01);
`else
    chk("low write lands", rb, 8'hAA);
    chk("wp_err tied", {7'b0, bus.wp_err}, 8'h00);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vc32_mem_responder.md
# vc32_mem_responder

Memory-side responder for the vc32 external byte bus. It decodes the strobe protocol the vc32 CPU wrapper drives on its byte output and `latch_hi`/`latch_lo`/`write`/`ind` lines, and assembles the 22-bit byte address. It serves reads and writes from an internal byte RAM and drives read data back onto the CPU's byte input. It is used as the FPGA/companion-chip memory and as the bench memory model, and also provides a mailbox register that drives the CPU interrupt pin.

## Interface
- `PA`, 22: physical byte-address width carried by the protocol (hi byte carries `PA-16` bits).
- `AW`, 12: internal RAM address bits (2^AW bytes).
- `ROM_BYTES`, 256: size of the write-protected region (used only with `VC32_RESP_WPROT_EN`).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bus_in`  in  8  address/data byte from the CPU (its `uo_out`).
- `latch_hi`  in  1  high-address strobe.
- `latch_lo`  in  1  low-address strobe.
- `write`  in  1  write strobe.
- `ind`  in  1  byte index (address bit 0).
- `rdata_out`  out  8  read byte to the CPU (its `ui_in`); combinational.
- `irq`  out  1  interrupt to the CPU (its `uio_in[7]`).
- `proto_err`  out  1  sticky protocol-violation flag.
- `wp_err`  out  1  sticky write-protect violation flag.

## Operation
- Strobe coding, sampled each cycle:
  - `hi&!lo`: top address bits.
  - `hi&lo`: address [15:8].
  - `!hi&lo`: address [7:1]; `bus_in[0]` is ignored.
- Effective byte address is `{A[PA-1:1], ind}`, using live `ind`.
- FSM states: `IDLE`, `GOT_HI`, `GOT_MID`, `ADDR_OK`.
  - `IDLE`: on `hi&!lo`, capture `A[PA-1:16]=bus_in[PA-17:0]` and go to `GOT_HI`. `lo=1` or `write=1` sets `proto_err`.
  - `GOT_HI`: on `hi&lo`, capture `A[15:8]` and go to `GOT_MID`. Any other strobe combination sets `proto_err` and returns to `IDLE`.
  - `GOT_MID`: on `!hi&lo`, capture `A[7:1]` and go to `ADDR_OK`. Otherwise set `proto_err` and go to `IDLE`.
  - `ADDR_OK`:
    - `write=1` writes `bus_in` to `{A,ind}` at the clock edge; stay in `ADDR_OK`, so back-to-back byte writes are allowed.
    - `hi&!lo` starts a new transaction (capture hi, go to `GOT_HI`).
    - `lo=1` sets `proto_err` and goes to `IDLE`.
    - All-zero strobes: stay.
- Read data (`rdata_out`):
  - In `GOT_MID` with `!hi&lo`: `mem[{A[PA-1:8], bus_in[7:1], ind}]`, using the live low address.
  - In `ADDR_OK` with `write=0` and `lo=0`: `mem[{A, ind}]`.
  - Otherwise 8'h00.
- RAM index is the byte address truncated to `AW` bits; higher addresses alias. RAM contents are not reset.
- Mailbox at byte address all-ones (22'h3FFFFF):
  - A write sets `irq<=bus_in[0]`; RAM is not written.
  - A read returns `{7'b0, irq}`.
  - The mailbox takes precedence over the aliased RAM byte.
- `proto_err` and `wp_err` clear only on reset.

## Timing
- Reset (async assert, synchronous-safe deassert path internal):
  - State `IDLE`; `irq=0`, `proto_err=0`, `wp_err=0`; `rdata_out=0` immediately.
  - A transaction interrupted by reset performs no write.
- Read, 16-bit: cycles C1 `hi`, C2 `hi&lo`, C3 `lo`, C4 none.
  - Byte `{A,ind}` (ind=0) is valid during C3.
  - Byte `{A,1}` is valid during C4.
  - Zero wait states; the CPU samples at the end of each cycle.
- Read, 8-bit: only C3 is used; `ind` selects the byte.
- Write: C1–C3 as for a read, then C4 `write`, `ind=~mask0`, one byte. Optionally C5 `write&ind=1` carries the high byte.
- RAM/mailbox updates take effect at the end of the write cycle and are readable on the next transaction. `irq` updates on the edge ending that cycle.
- Simultaneous `write` with `hi` or `lo` in `ADDR_OK`: strobe rules take priority, no write, `proto_err` set.

## Configuration
- `VC32_RESP_WPROT_EN` defined:
  - Writes to byte addresses `< ROM_BYTES` (full address compare) are dropped and set `wp_err`.
  - Reads of that region are unaffected.
- Not defined: all writes land; `wp_err` is tied 0; `ROM_BYTES` is unused.

## Test plan
- 16-bit write 0xBEEF to 0x012344 (C4 `ind=0` data EF, C5 `ind=1` data BE), then 16-bit read of 0x012344 -> `rdata_out`=EF in C3, BE in C4.
- Byte write 0x5A with `ind=1` to 0x000101 after preloading 0x000100=0x11 -> read returns 0x11 then 0x5A; aliased read of 0x001100 (AW=12) returns same bytes.
- Byte write 0x01 to 0x3FFFFF -> `irq`=1 one edge later, RAM index 0xFFF unchanged; write 0x00 -> `irq`=0; read returns 0x00.
- `lo=1` in `IDLE` -> `proto_err`=1 and stays 1; a following legal write/read of 0x000020 still completes correctly.
- Async `rst_n` low during `GOT_MID`, with `write` pulsed afterwards -> `rdata_out`=0 and `irq`=0 at once, state `IDLE`, target byte unchanged.
- With `VC32_RESP_WPROT_EN`, `ROM_BYTES`=256: write 0xAA to 0x000010 -> byte unchanged, `wp_err`=1; without the macro the same write lands and `wp_err`=0.
